nand_stimulus_checker: RTL and testbench

//  Drives the operand side of the reliable-NAND test circuit and checks its results.

---
 rtl/nand_stimulus_checker.sv | 153 +++++++++++++++
 tb/tb_nand_stimulus_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nand_stimulus_checker.sv
// Operand generator and result checker for the reliable-NAND test circuit.
// Two Galois LFSRs supply the operand pairs. Each pair is held for a settle
// window. After that window the block waits for the circuit's valid_i, then
// compares z_i with ~(x & y). It keeps saturating vector, word-error and
// bit-error counts.
module nand_stimulus_checker #(
  parameter int N              = 10,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_i,
  input  logic [31:0]   num_vectors_i,
  input  logic [31:0]   seed_i,
  output logic [N-1:0]  x_o,
  output logic [N-1:0]  y_o,
  input  logic [N-1:0]  z_i,
  input  logic          valid_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_o,
  output logic [31:0]   vec_count_o,
  output logic [31:0]   word_err_o,
  output logic [31:0]   bit_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
  localparam logic [31:0] SEED_A_ZERO  = 32'hACE1_ACE1;
  localparam logic [31:0] SEED_B_ZERO  = 32'h531E_531E;
  // Last count value in SETTLE/WAIT; SETTLE is skipped entirely when its length is 0.
  localparam logic [31:0] SETTLE_LAST  = 32'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state, state_nxt;
  logic [31:0]   lfsr_a, lfsr_b;
  logic [31:0]   lfsr_a_nxt, lfsr_b_nxt;
  logic [31:0]   num_vec_q;
  logic [31:0]   settle_cnt;
  logic [31:0]   wait_cnt;
  logic [N-1:0]  z_q;
  logic [N-1:0]  diff;
  logic [31:0]   vec_count_nxt;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  function automatic logic [31:0] popcount(input logic [N-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

  assign lfsr_a_nxt    = lfsr_step(lfsr_a);
  assign lfsr_b_nxt    = lfsr_step(lfsr_b);
  assign diff          = z_q ^ ~(x_o & y_o);
  assign vec_count_nxt = sat_add(vec_count_o, 32'd1);
  assign busy_o        = (state == S_LOAD) || (state == S_SETTLE) ||
                         (state == S_WAIT) || (state == S_CHECK);
  assign done_o        = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_nxt = (num_vectors_i == 32'd0) ? S_DONE : S_LOAD;
      S_LOAD:         state_nxt = (SETTLE_CYCLES == 0) ? S_WAIT : S_SETTLE;
      S_SETTLE:       if (settle_cnt == SETTLE_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (valid_i)                        state_nxt = S_CHECK;
        else if (wait_cnt == TIMEOUT_LAST)  state_nxt = S_DONE;
      end
      S_CHECK:        state_nxt = (vec_count_nxt == num_vec_q) ? S_DONE : S_LOAD;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Operand generation, result capture and error accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_a      <= 32'h0000_0001;
      lfsr_b      <= 32'h0000_0002;
      x_o         <= '0;
      y_o         <= '0;
      z_q         <= '0;
      num_vec_q   <= '0;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      timeout_o   <= 1'b0;
      vec_count_o <= '0;
      word_err_o  <= '0;
      bit_err_o   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            vec_count_o <= '0;
            word_err_o  <= '0;
            bit_err_o   <= '0;
            timeout_o   <= 1'b0;
            num_vec_q   <= num_vectors_i;
            if (seed_i == 32'd0) begin
              lfsr_a <= SEED_A_ZERO;
              lfsr_b <= SEED_B_ZERO;
            end else begin
              lfsr_a <= seed_i;
              lfsr_b <= ~seed_i;
            end
          end
        end
        S_LOAD: begin
          lfsr_a     <= lfsr_a_nxt;
          lfsr_b     <= lfsr_b_nxt;
          x_o        <= lfsr_a_nxt[N-1:0];
          y_o        <= lfsr_b_nxt[N-1:0];
          settle_cnt <= '0;
          wait_cnt   <= '0;
        end
        S_SETTLE: settle_cnt <= settle_cnt + 32'd1;
        S_WAIT: begin
          if (valid_i)                       z_q       <= z_i;
          else if (wait_cnt == TIMEOUT_LAST) timeout_o <= 1'b1;
          else                               wait_cnt  <= wait_cnt + 32'd1;
        end
        S_CHECK: begin
          vec_count_o <= vec_count_nxt;
          word_err_o  <= sat_add(word_err_o, {31'd0, diff != '0});
          bit_err_o   <= sat_add(bit_err_o, popcount(diff));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_stimulus_checker.sv
// Bench for nand_stimulus_checker. It uses a behavioural NAND circuit with
// 2-cycle latency and operand-keyed fault injection. A sequence-level
// reference model supplies the expected counts and operands.
module tb_nand_stimulus_checker;

  localparam int N      = 10;
  localparam int SETTLE = 2;
  localparam int TMO    = 16;
  localparam logic [31:0] POLY_MASK = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [31:0]   num_vectors_i = '0;
  logic [31:0]   seed_i = '0;
  logic [N-1:0]  x_o, y_o, z_i;
  logic          valid_i = 1'b0;
  logic          busy_o, done_o, timeout_o;
  logic [31:0]   vec_count_o, word_err_o, bit_err_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cut_mode = 0;   // 0 ideal, 1 flip bit0 when x[1:0]==0, 2 multi-bit faults
  int vld_mode = 1;   // 0 never valid, 1 always valid, 2 valid 3/4 of cycles

  logic [N-1:0] p1 = '0, p2 = '0;

  nand_stimulus_checker #(.N(N), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .num_vectors_i(num_vectors_i),
    .seed_i(seed_i), .x_o(x_o), .y_o(y_o), .z_i(z_i), .valid_i(valid_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .vec_count_o(vec_count_o), .word_err_o(word_err_o), .bit_err_o(bit_err_o)
  );

  always #5 clk = ~clk;

  // Error pattern the faulty circuit adds to its result, chosen from the operands.
  function automatic logic [N-1:0] inj(input int mode, input logic [N-1:0] x, input logic [N-1:0] y);
    case (mode)
      1:       return (x[1:0] == 2'b00) ? N'(1) : N'(0);
      2:       return x & ~y & N'(10'h2A5);
      default: return N'(0);
    endcase
  endfunction

  // Circuit under test: NAND with two-cycle latency.
  always @(posedge clk) begin
    p1 <= ~(x_o & y_o) ^ inj(cut_mode, x_o, y_o);
    p2 <= p1;
  end
  assign z_i = p2;

  always @(negedge clk)
    valid_i = (vld_mode == 1) || (vld_mode == 2 && $urandom_range(3) != 0);

  function automatic logic [31:0] galois_next(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ POLY_MASK;
    return s >> 1;
  endfunction

  // Whole-run reference: operand sequence and accumulated error counts.
  task automatic ref_run(input logic [31:0] seed, input int num, input int mode,
                         output logic [31:0] werr, output logic [31:0] berr,
                         output logic [N-1:0] xl, output logic [N-1:0] yl);
    logic [31:0] a, b;
    logic [N-1:0] m;
    a = (seed == 0) ? 32'hACE1_ACE1 : seed;
    b = (seed == 0) ? 32'h531E_531E : ~seed;
    werr = 0; berr = 0; xl = '0; yl = '0;
    for (int k = 0; k < num; k++) begin
      a = galois_next(a);
      b = galois_next(b);
      xl = a[N-1:0];
      yl = b[N-1:0];
      m = inj(mode, xl, yl);
      if (m != '0) werr++;
      berr += $countones(m);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] seed, input logic [31:0] num);
    @(negedge clk);
    seed_i = seed;
    num_vectors_i = num;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (!done_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, 32'(done_o), 32'd1);
  endtask

  task automatic full_run(input string tag, input logic [31:0] seed, input int num,
                          input int mode, input int vmode);
    logic [31:0] werr, berr;
    logic [N-1:0] xl, yl;
    cut_mode = mode;
    vld_mode = vmode;
    start_run(seed, num);
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    wait_done(tag, num * 40 + 100);
    ref_run(seed, num, mode, werr, berr, xl, yl);
    check({tag, "_vec"}, vec_count_o, 32'(num));
    check({tag, "_werr"}, word_err_o, werr);
    check({tag, "_berr"}, bit_err_o, berr);
    check({tag, "_tmo"}, 32'(timeout_o), 32'd0);
    check({tag, "_x"}, 32'(x_o), 32'(xl));
    check({tag, "_y"}, 32'(y_o), 32'(yl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] werr, berr, s;
    logic [N-1:0] xl, yl, xb, yb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);
    check("rst_vec", vec_count_o, 32'd0);
    check("rst_werr", word_err_o, 32'd0);
    check("rst_berr", bit_err_o, 32'd0);
    check("rst_x", 32'(x_o), 32'd0);
    check("rst_y", 32'(y_o), 32'd0);
    reset_n = 1'b1;

    // Zero-length run: done next cycle, operands untouched
    xb = x_o; yb = y_o;
    start_run(32'h1234_5678, 32'd0);
    check("zero_done", 32'(done_o), 32'd1);
    check("zero_busy", 32'(busy_o), 32'd0);
    check("zero_vec", vec_count_o, 32'd0);
    check("zero_x", 32'(x_o), 32'(xb));
    check("zero_y", 32'(y_o), 32'(yb));

    // Ideal circuit, long run
    full_run("ideal", 32'd1, 1000, 0, 1);
    // Single-bit faults on a subset of vectors
    full_run("bit0", 32'd1, 100, 1, 1);
    // Randomized seeds, lengths, faults and valid timing
    for (int r = 0; r < 4; r++)
      full_run("rand", $urandom | 32'd1, 20 + $urandom_range(40), 2, 2);

    // Zero seed behaves as seed 32'hACE1_ACE1
    cut_mode = 2;
    vld_mode = 1;
    for (int k = 1; k <= 8; k++) begin
      start_run(32'd0, 32'(k));
      wait_done("seed0", k * 40 + 100);
      ref_run(32'hACE1_ACE1, k, 2, werr, berr, xl, yl);
      check("seed0_x", 32'(x_o), 32'(xl));
      check("seed0_y", 32'(y_o), 32'(yl));
      check("seed0_berr", bit_err_o, berr);
    end

    // start_i while busy is ignored
    s = $urandom | 32'd1;
    cut_mode = 2;
    vld_mode = 2;
    start_run(s, 32'd60);
    repeat (17) @(negedge clk);
    check("ign_busy", 32'(busy_o), 32'd1);
    seed_i = 32'hDEAD_BEEF; num_vectors_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    seed_i = 32'd0; num_vectors_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("ign", 60 * 40);
    ref_run(s, 60, 2, werr, berr, xl, yl);
    check("ign_vec", vec_count_o, 32'd60);
    check("ign_werr", word_err_o, werr);
    check("ign_berr", bit_err_o, berr);
    check("ign_x", 32'(x_o), 32'(xl));

    // Timeout: valid never arrives; done exactly 1+SETTLE+TMO cycles after start
    vld_mode = 0;
    start_run(32'd77, 32'd5);
    repeat (SETTLE + TMO) @(negedge clk);
    check("tmo_early", 32'(done_o), 32'd0);
    @(negedge clk);
    check("tmo_done", 32'(done_o), 32'd1);
    check("tmo_flag", 32'(timeout_o), 32'd1);
    check("tmo_vec", vec_count_o, 32'd0);
    ref_run(32'd77, 1, 0, werr, berr, xl, yl);
    check("tmo_x", 32'(x_o), 32'(xl));
    // Next start clears the sticky timeout
    full_run("after_tmo", 32'h0BAD_F00D, 10, 1, 1);

    // Asynchronous reset while waiting for valid_i
    cut_mode = 0;
    vld_mode = 1;
    start_run(32'd99, 32'd50);
    repeat (22) @(negedge clk);
    vld_mode = 0;
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy_o), 32'd1);
    check("mid_vec_nz", 32'(vec_count_o != 32'd0), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_vec", vec_count_o, 32'd0);
    check("arst_x", 32'(x_o), 32'd0);
    check("arst_y", 32'(y_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    full_run("fresh", 32'h5A5A_0001, 30, 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
